assert_enable_ctrl: RTL and testbench
=====================================

Name: assert_enable_ctrl

Overview:
Run-time controller that decides when a bank of NUM_CHK checker channels may fire, such as immediate-assertion groups or scoreboard comparators. After an arm request it waits a programmable hold-off, then enables the unmasked channels. While enabled it counts pass and fail results, keeps sticky per-channel fail flags, and halts checking once a programmable fail limit is reached. It replaces ad-hoc reset-qualified disables with a single sequenced enable source.

Parameters:
NUM_CHK, 4, number of checker channels
CNT_W, 8, width of pass/fail counters and of the fail limit
HOLD_W, 8, width of the hold-off counter

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous active-high reset
arm  in  1  start request, sampled in IDLE only
stop  in  1  return-to-IDLE request, honoured in any non-IDLE state
cfg_holdoff  in  HOLD_W  hold-off length in cycles, latched on arm
cfg_mask  in  NUM_CHK  1 = channel disabled, latched on arm
cfg_fail_limit  in  CNT_W  total fails that trigger HALTED; 0 = never halt, latched on arm
chk_valid  in  NUM_CHK  channel produced a result this cycle
chk_pass  in  NUM_CHK  result per channel (1 = pass); ignored when valid=0
chk_en  out  NUM_CHK  enable to checkers
pass_cnt  out  CNT_W  total counted passes, saturating
fail_cnt  out  CNT_W  total counted fails, saturating
fail_flags  out  NUM_CHK  sticky per-channel fail seen
state  out  2  IDLE=0, HOLDOFF=1, ARMED=2, HALTED=3
halted  out  1  1 when state==HALTED

Behaviour:
- Reset (async, immediate):
  - state=IDLE; pass_cnt=0, fail_cnt=0, fail_flags=0.
  - Hold-off counter=0; latched mask/limit=0.
  - chk_en=0 and halted=0 in the same instant, since both decode from state.
- chk_en = (state==ARMED) ? ~mask_q : 0. halted = (state==HALTED). Both are combinational from registers.
- IDLE:
  - arm=1 and stop=0 latch cfg_mask, cfg_fail_limit and cfg_holdoff, and clear pass_cnt, fail_cnt and fail_flags.
  - Next state is HOLDOFF if cfg_holdoff!=0, else ARMED.
  - arm and stop together: stop wins; stay in IDLE, nothing latched or cleared.
  - Counters and flags otherwise hold their values from the previous run.
- HOLDOFF:
  - Lasts exactly cfg_holdoff cycles. The counter loads cfg_holdoff and decrements each cycle.
  - At count==1 the next state is ARMED.
  - stop goes to IDLE.
  - arm is ignored.
- ARMED:
  - Per cycle: hit_p = chk_valid & chk_pass & chk_en; hit_f = chk_valid & ~chk_pass & chk_en.
  - pass_cnt += popcount(hit_p) and fail_cnt += popcount(hit_f). Both saturate at 2^CNT_W-1 and never wrap.
  - fail_flags |= hit_f.
  - Updates are registered and visible the cycle after the result.
  - If limit_q!=0 and the updated fail_cnt >= limit_q, next state is HALTED.
  - stop goes to IDLE. That cycle's results are still counted, and stop takes priority over the halt transition.
  - arm is ignored.
- HALTED:
  - chk_en=0; counters and flags are frozen.
  - stop goes to IDLE; arm is ignored.
- Channels masked or outside ARMED never affect counters or flags, regardless of chk_valid.
- cfg_* changes outside the arm cycle have no effect.
- A saturated fail_cnt still compares against limit_q, so a limit of 2^CNT_W-1 remains reachable.

Test Plan:
- Reset then arm, cfg_holdoff=5, mask=4'b0000 → state=1 for exactly 5 cycles, then state=2 and chk_en=4'hF.
- Hold-off zero: arm with cfg_holdoff=0, mask=4'b1010 → ARMED on the next cycle with chk_en=4'b0101. Drive valid=4'hF, pass=4'h0 for 1 cycle → fail_cnt=2 and fail_flags=4'b0101.
- Fail limit: cfg_fail_limit=3, all channels enabled. Cycle 1: valid=4'hF, pass=4'b1110 gives fail_cnt=1, pass_cnt=3. Cycle 2: pass=4'b1100 gives fail_cnt=3, state=3, halted=1, chk_en=0. Further valid inputs leave the counts unchanged.
- Saturation: CNT_W=8, limit=0, 70 cycles with valid=4'hF, pass=4'hF → pass_cnt saturates at 255 and does not wrap.
- Priority/ignore:
  - arm and stop together in IDLE → stays IDLE, counters unchanged.
  - stop in ARMED in the cycle the limit is reached → IDLE, with that cycle's fails counted.
  - arm in ARMED → no restart.
- Async reset mid-ARMED (rst high between clock edges) → chk_en=0 and state=0 immediately, counters 0. Run arm again → normal hold-off.

Source files
------------

// File: rtl/assert_enable_ctrl_if.sv
// Bus bundle for assert_enable_ctrl. It carries the arm/stop control, the
// configuration, the per-channel checker results and the status outputs.
interface assert_enable_ctrl_if #(
  parameter int NUM_CHK = 4,
  parameter int CNT_W   = 8,
  parameter int HOLD_W  = 8
);
  logic               arm;
  logic               stop;
  logic [HOLD_W-1:0]  cfg_holdoff;
  logic [NUM_CHK-1:0] cfg_mask;
  logic [CNT_W-1:0]   cfg_fail_limit;
  logic [NUM_CHK-1:0] chk_valid;
  logic [NUM_CHK-1:0] chk_pass;
  logic [NUM_CHK-1:0] chk_en;
  logic [CNT_W-1:0]   pass_cnt;
  logic [CNT_W-1:0]   fail_cnt;
  logic [NUM_CHK-1:0] fail_flags;
  logic [1:0]         state;
  logic               halted;

  modport slave (
    input  arm, stop, cfg_holdoff, cfg_mask, cfg_fail_limit, chk_valid, chk_pass,
    output chk_en, pass_cnt, fail_cnt, fail_flags, state, halted
  );

  modport master (
    output arm, stop, cfg_holdoff, cfg_mask, cfg_fail_limit, chk_valid, chk_pass,
    input  chk_en, pass_cnt, fail_cnt, fail_flags, state, halted
  );
endinterface

// File: rtl/assert_enable_ctrl.sv
// Sequenced enable source for a bank of checker channels: arm, hold-off, armed
// counting with saturating pass/fail totals, sticky fail flags, halt on fail limit.
module assert_enable_lane (
  input  logic valid,
  input  logic pass,
  input  logic en,
  output logic hit_p,
  output logic hit_f
);
  assign hit_p = valid &  pass & en;
  assign hit_f = valid & ~pass & en;
endmodule

module assert_enable_ctrl #(
  parameter int NUM_CHK = 4,
  parameter int CNT_W   = 8,
  parameter int HOLD_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  assert_enable_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, HOLDOFF = 2'd1, ARMED = 2'd2, HALTED = 2'd3} state_e;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [NUM_CHK-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic [NUM_CHK-1:0] flags_q, flags_d;

  logic [NUM_CHK-1:0] en, hit_p, hit_f;
  logic [CNT_W:0]     pcnt_p, pcnt_f, pass_sum, fail_sum;
  logic [CNT_W-1:0]   pass_sat, fail_sat;

  // Outside ARMED the enables are zero, so the hit vectors are zero as well.
  assign en = (state_q == ARMED) ? ~mask_q : '0;

  for (genvar g = 0; g < NUM_CHK; g++) begin : g_lane
    assert_enable_lane u_lane (
      .valid (bus.chk_valid[g]),
      .pass  (bus.chk_pass[g]),
      .en    (en[g]),
      .hit_p (hit_p[g]),
      .hit_f (hit_f[g])
    );
  end

  always_comb begin
    pcnt_p = '0;
    pcnt_f = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      pcnt_p = pcnt_p + {{CNT_W{1'b0}}, hit_p[i]};
      pcnt_f = pcnt_f + {{CNT_W{1'b0}}, hit_f[i]};
    end
    pass_sum = {1'b0, pass_q} + pcnt_p;
    fail_sum = {1'b0, fail_q} + pcnt_f;
    pass_sat = pass_sum[CNT_W] ? '1 : pass_sum[CNT_W-1:0];
    fail_sat = fail_sum[CNT_W] ? '1 : fail_sum[CNT_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    mask_d  = mask_q;
    limit_d = limit_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (bus.arm && !bus.stop) begin
          mask_d  = bus.cfg_mask;
          limit_d = bus.cfg_fail_limit;
          hold_d  = bus.cfg_holdoff;
          pass_d  = '0;
          fail_d  = '0;
          flags_d = '0;
          state_d = (bus.cfg_holdoff != '0) ? HOLDOFF : ARMED;
        end
      end
      HOLDOFF: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (hold_q <= HOLD_W'(1)) begin
          hold_d  = '0;
          state_d = ARMED;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ARMED: begin
        pass_d  = pass_sat;
        fail_d  = fail_sat;
        flags_d = flags_q | hit_f;
        // The saturated total still compares, so an all-ones limit stays reachable.
        if (bus.stop)
          state_d = IDLE;
        else if (limit_q != '0 && fail_sat >= limit_q)
          state_d = HALTED;
      end
      HALTED: begin
        if (bus.stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      mask_q  <= '0;
      limit_q <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      mask_q  <= mask_d;
      limit_q <= limit_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      flags_q <= flags_d;
    end
  end

  assign bus.chk_en     = en;
  assign bus.pass_cnt   = pass_q;
  assign bus.fail_cnt   = fail_q;
  assign bus.fail_flags = flags_q;
  assign bus.state      = state_q;
  assign bus.halted     = (state_q == HALTED);
endmodule

// File: tb/tb_assert_enable_ctrl.sv
// Directed bench for assert_enable_ctrl: hold-off timing, masking, fail limit,
// saturation, stop/arm priority and asynchronous reset.
module tb_assert_enable_ctrl;
  localparam int NUM_CHK = 4;
  localparam int CNT_W   = 8;
  localparam int HOLD_W  = 8;

  logic clk, rst;
  int   n_chk, n_fail;

  assert_enable_ctrl_if #(.NUM_CHK(NUM_CHK), .CNT_W(CNT_W), .HOLD_W(HOLD_W)) bus ();

  assert_enable_ctrl #(.NUM_CHK(NUM_CHK), .CNT_W(CNT_W), .HOLD_W(HOLD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_cfg(input logic [HOLD_W-1:0] ho, input logic [NUM_CHK-1:0] m,
                         input logic [CNT_W-1:0] lim);
    bus.cfg_holdoff    = ho;
    bus.cfg_mask       = m;
    bus.cfg_fail_limit = lim;
    bus.arm            = 1'b1;
    tick();
    bus.arm            = 1'b0;
  endtask

  task automatic results(input logic [NUM_CHK-1:0] v, input logic [NUM_CHK-1:0] p);
    bus.chk_valid = v;
    bus.chk_pass  = p;
    tick();
    bus.chk_valid = '0;
    bus.chk_pass  = '0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.arm = 1'b0;
    bus.stop = 1'b0;
    bus.cfg_holdoff = '0;
    bus.cfg_mask = '0;
    bus.cfg_fail_limit = '0;
    bus.chk_valid = '0;
    bus.chk_pass = '0;
    #3;
    check("rst_state", 32'(bus.state), 0);
    check("rst_en", 32'(bus.chk_en), 0);
    check("rst_halted", 32'(bus.halted), 0);
    check("rst_pass", 32'(bus.pass_cnt), 0);
    check("rst_fail", 32'(bus.fail_cnt), 0);
    check("rst_flags", 32'(bus.fail_flags), 0);
    rst = 1'b0;
    tick();

    // Hold-off of 5 cycles
    arm_cfg(8'd5, 4'b0000, 8'd0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("ho5_state_%0d", i), 32'(bus.state), 1);
      check($sformatf("ho5_en_%0d", i), 32'(bus.chk_en), 0);
      tick();
    end
    check("ho5_armed", 32'(bus.state), 2);
    check("ho5_en", 32'(bus.chk_en), 32'hF);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    check("stop_idle", 32'(bus.state), 0);

    // Zero hold-off with mask; cfg changes while armed have no effect
    arm_cfg(8'd0, 4'b1010, 8'd0);
    check("ho0_state", 32'(bus.state), 2);
    check("ho0_en", 32'(bus.chk_en), 32'b0101);
    bus.cfg_mask = 4'b0000;
    results(4'hF, 4'h0);
    check("mask_fail", 32'(bus.fail_cnt), 2);
    check("mask_pass", 32'(bus.pass_cnt), 0);
    check("mask_flags", 32'(bus.fail_flags), 32'b0101);
    check("mask_en_held", 32'(bus.chk_en), 32'b0101);
    bus.arm = 1'b1; bus.cfg_holdoff = 8'd7; tick(); bus.arm = 1'b0;
    check("arm_in_armed_state", 32'(bus.state), 2);
    check("arm_in_armed_fail", 32'(bus.fail_cnt), 2);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    check("idle_hold_fail", 32'(bus.fail_cnt), 2);
    results(4'hF, 4'h0);
    check("idle_ignore_fail", 32'(bus.fail_cnt), 2);

    // arm and stop together in IDLE
    bus.arm = 1'b1; bus.stop = 1'b1; bus.cfg_holdoff = 8'd0;
    tick();
    bus.arm = 1'b0; bus.stop = 1'b0;
    check("armstop_state", 32'(bus.state), 0);
    check("armstop_fail", 32'(bus.fail_cnt), 2);
    check("armstop_flags", 32'(bus.fail_flags), 32'b0101);

    // Fail limit of 3
    arm_cfg(8'd0, 4'b0000, 8'd3);
    check("lim_cleared", 32'(bus.fail_cnt), 0);
    results(4'hF, 4'b1110);
    check("lim_c1_fail", 32'(bus.fail_cnt), 1);
    check("lim_c1_pass", 32'(bus.pass_cnt), 3);
    check("lim_c1_state", 32'(bus.state), 2);
    results(4'hF, 4'b1100);
    check("lim_c2_fail", 32'(bus.fail_cnt), 3);
    check("lim_c2_pass", 32'(bus.pass_cnt), 5);
    check("lim_c2_state", 32'(bus.state), 3);
    check("lim_c2_halted", 32'(bus.halted), 1);
    check("lim_c2_en", 32'(bus.chk_en), 0);
    bus.arm = 1'b1;
    results(4'hF, 4'h0);
    bus.arm = 1'b0;
    check("halt_fail", 32'(bus.fail_cnt), 3);
    check("halt_pass", 32'(bus.pass_cnt), 5);
    check("halt_flags", 32'(bus.fail_flags), 32'b0011);
    check("halt_state", 32'(bus.state), 3);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    check("halt_stop", 32'(bus.state), 0);

    // stop in the cycle the limit is reached
    arm_cfg(8'd0, 4'b0000, 8'd2);
    bus.stop = 1'b1;
    results(4'hF, 4'b1100);
    bus.stop = 1'b0;
    check("stoplim_state", 32'(bus.state), 0);
    check("stoplim_fail", 32'(bus.fail_cnt), 2);
    check("stoplim_pass", 32'(bus.pass_cnt), 2);

    // Pass counter saturation
    arm_cfg(8'd0, 4'b0000, 8'd0);
    bus.chk_valid = 4'hF; bus.chk_pass = 4'hF;
    for (int i = 0; i < 63; i++) tick();
    check("sat_252", 32'(bus.pass_cnt), 252);
    tick();
    check("sat_255", 32'(bus.pass_cnt), 255);
    for (int i = 0; i < 6; i++) tick();
    check("sat_hold", 32'(bus.pass_cnt), 255);
    check("sat_fail", 32'(bus.fail_cnt), 0);
    bus.chk_valid = '0; bus.chk_pass = '0;
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;

    // All-ones limit is reachable
    arm_cfg(8'd0, 4'b0000, 8'd255);
    bus.chk_valid = 4'hF; bus.chk_pass = 4'h0;
    for (int i = 0; i < 63; i++) tick();
    check("lim255_252", 32'(bus.fail_cnt), 252);
    check("lim255_armed", 32'(bus.state), 2);
    tick();
    check("lim255_fail", 32'(bus.fail_cnt), 255);
    check("lim255_halt", 32'(bus.state), 3);
    bus.chk_valid = '0;
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;

    // Asynchronous reset while armed
    arm_cfg(8'd0, 4'b0000, 8'd0);
    results(4'hF, 4'hF);
    check("pre_rst_pass", 32'(bus.pass_cnt), 4);
    #2 rst = 1'b1;
    #1;
    check("arst_state", 32'(bus.state), 0);
    check("arst_en", 32'(bus.chk_en), 0);
    check("arst_pass", 32'(bus.pass_cnt), 0);
    #1 rst = 1'b0;
    tick();
    arm_cfg(8'd3, 4'b0000, 8'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ho3_state_%0d", i), 32'(bus.state), 1);
      tick();
    end
    check("ho3_armed", 32'(bus.state), 2);
    check("ho3_en", 32'(bus.chk_en), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
